// File: rtl/uart_tx_mmio.sv
//------------------------------------------------------------------------------
// uart_tx_mmio -- memory-mapped UART transmitter with a byte FIFO, on the
// CPU data bus next to the data memory. Frames are 8N1 by default.
// Optional build macro: UART_PARITY_EN (adds a parity bit between the data
// bits and the stop bit; CTRL bit2 selects odd parity, 0 = even).
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst    asynchronous active-high reset
//   addr   data byte address [11:0], same bits as the data memory sees
//   rw     1 = write (sampled at the clk edge), 0 = read
//   wdata  64-bit store data
//   rdata  combinational register read data, 0 outside the window
//   tx     serial output, registered, idles high
//   irq    transmit-done interrupt: irq_en & FIFO empty & FSM idle
//
// Register map (byte offsets from BASE_ADDR, 32-byte window):
//   0x00 TXDATA  W: push wdata[7:0]; reads 0
//   0x08 STATUS  R: [0] full [1] empty [2] busy [3] overflow (W1C)
//                   [11:8] FIFO count (zero-extended/truncated to 4 bits)
//   0x10 CTRL    RW: [0] enable [1] irq_en [2] odd parity (parity build only)
//   0x18 reserved, reads 0, writes ignored
//------------------------------------------------------------------------------

// uart_tx_fifo: generic single-clock FIFO with first-word-fall-through read port.
// Latency: a push at edge N is visible on pop_dat/count/empty right after edge N.
// Backpressure: push ignored when full unless popping the same cycle; pop ignored when empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted; the write lands in the slot being read out this edge.
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    // Pointers are AW bits wide; DEPTH is a power of two so they wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// uart_tx_mmio: CPU-bus register window feeding a TX FIFO and a serial framer.
// Latency: TXDATA write at edge N (FIFO empty, enabled, idle) pops and drives the start bit at edge N+1.
// Backpressure: none on the bus; a push to a full FIFO with no same-cycle pop is dropped and sets overflow.
module uart_tx_mmio #(
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [11:0] BASE_ADDR  = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic        rw,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        tx,
    output logic        irq
);
    localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] DIV_LAST = BW'(CLK_DIV - 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [4:0] OFF_TXDATA = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic in_win;
    logic wr_txdata;
    logic wr_status;
    logic wr_ctrl;

    // The window is 32-byte aligned, so only addr[11:5] select it.
    assign in_win    = (addr[11:5] == BASE_ADDR[11:5]);
    assign wr_txdata = rw & in_win & (addr[4:0] == OFF_TXDATA);
    assign wr_status = rw & in_win & (addr[4:0] == OFF_STATUS);
    assign wr_ctrl   = rw & in_win & (addr[4:0] == OFF_CTRL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            ctrl_en;
    logic            irq_en;
    logic            overflow;
`ifdef UART_PARITY_EN
    logic            odd_sel;
    logic            par_bit;
`endif

    logic            busy;
    logic            frame_end;

    // FIFO interface
    logic            fifo_pop;
    logic [7:0]      fifo_dat;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            ovf_set;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_txdata),
        .push_dat (wdata[7:0]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign busy      = (state != S_IDLE);
    assign frame_end = (state == S_STOP) && (baud_cnt == '0);

    // A new frame is loaded either from idle or straight out of the last
    // stop-bit cycle, which gives back-to-back frames with no idle gap.
    assign fifo_pop  = ctrl_en & ~fifo_empty & ((state == S_IDLE) | frame_end);
    assign ovf_set   = wr_txdata & fifo_full & ~fifo_pop;

    assign irq = irq_en & fifo_empty & ~busy;

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en  <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
`ifdef UART_PARITY_EN
            odd_sel  <= 1'b0;
`endif
        end else begin
            if (wr_ctrl) begin
                ctrl_en <= wdata[0];
                irq_en  <= wdata[1];
`ifdef UART_PARITY_EN
                odd_sel <= wdata[2];
`endif
            end
            // Clear and set target different offsets, so they never collide.
            if (wr_status && wdata[3]) overflow <= 1'b0;
            else if (ovf_set)          overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serial framer. The baud counter reloads CLK_DIV-1 whenever a state
    // (or a new bit) begins and the state advances when it reaches 0, so
    // every bit lasts exactly CLK_DIV cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
`ifdef UART_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else if (fifo_pop) begin
            // Only asserted in IDLE or on the final STOP cycle.
            shreg    <= fifo_dat;
            baud_cnt <= DIV_LAST;
            tx       <= 1'b0;
            state    <= S_START;
`ifdef UART_PARITY_EN
            par_bit  <= ^fifo_dat;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                end
                S_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= DIV_LAST;
                        bit_idx  <= 3'd0;
                        tx       <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= DIV_LAST;
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx    <= par_bit ^ odd_sel;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= DIV_LAST;
                        tx       <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    // Reaching here with baud_cnt == 0 means no pop was
                    // possible (disabled or FIFO empty): park in IDLE.
                    if (baud_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Combinational read port, same timing as the data memory.
    // ------------------------------------------------------------------
    logic [31:0] count_ext;
    logic [3:0]  count4;
    logic        unused_bits;

    // Zero-extend first, then keep the low nibble: covers both the
    // shallow (extend) and deep (truncate) FIFO cases.
    assign count_ext   = 32'(fifo_count);
    assign count4      = count_ext[3:0];
    assign unused_bits = ^{wdata[63:8], count_ext[31:4]};

    always_comb begin
        rdata = '0;
        if (in_win) begin
            case (addr[4:0])
                OFF_STATUS: rdata[11:0] = {count4, 4'b0000, overflow, busy, fifo_empty, fifo_full};
`ifdef UART_PARITY_EN
                OFF_CTRL:   rdata[2:0]  = {odd_sel, irq_en, ctrl_en};
`else
                OFF_CTRL:   rdata[1:0]  = {irq_en, ctrl_en};
`endif
                default:    rdata       = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio at CLK_DIV=4, FIFO_DEPTH=8, BASE_ADDR=0xF00.
// Bytes written to TXDATA that must appear on tx are queued; a serial
// receiver process decodes tx and pops/compares each frame in order.
module tb_uart_tx_mmio;
    localparam int          DIV  = 4;
    localparam logic [11:0] BASE = 12'hF00;
    localparam logic [11:0] A_TX = BASE + 12'h000;
    localparam logic [11:0] A_ST = BASE + 12'h008;
    localparam logic [11:0] A_CT = BASE + 12'h010;
    localparam logic [11:0] A_RS = BASE + 12'h018;
`ifdef UART_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif
    localparam int FLEN = FBITS * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] addr = A_ST;
    logic        rw = 1'b0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata;
    logic        tx;
    logic        irq;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sb_q[$];
    logic        odd_sel = 1'b0;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .rw    (rw),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx),
        .irq   (irq)
    );

    // Expected line level for bit slot k of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input logic odd, input int k);
        logic p;
        p = (^b) ^ odd;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && FBITS == 11) return p;
        return 1'b1;
    endfunction

    // Bus helpers: called at a negedge; put holds the write across one posedge.
    task automatic put(input logic [11:0] a, input logic [63:0] d);
        addr = a; rw = 1'b1; wdata = d;
        @(negedge clk);
    endtask

    task automatic release_bus();
        rw = 1'b0; addr = A_ST; wdata = '0;
    endtask

    task automatic ctrl_write(input logic [63:0] d);
        put(A_CT, d);
        release_bus();
        odd_sel = (FBITS == 11) ? d[2] : 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [63:0] d);
        addr = a; rw = 1'b0;
        #1;
        d = rdata;
    endtask

    // Serial receiver: samples mid-bit on falling clock edges. Frames that
    // overlap a reset are discarded.
    initial begin : monitor
        logic [7:0] b;
        logic [7:0] e;
        logic       aborted, start_bit, stop_bit, par, ep;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && rst === 1'b0) begin
                aborted = 1'b0; b = '0; par = 1'b0;
                repeat (DIV/2) begin @(negedge clk); if (rst) aborted = 1'b1; end
                start_bit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) begin @(negedge clk); if (rst) aborted = 1'b1; end
                    b[i] = tx;
                end
                if (FBITS == 11) begin
                    repeat (DIV) begin @(negedge clk); if (rst) aborted = 1'b1; end
                    par = tx;
                end
                repeat (DIV) begin @(negedge clk); if (rst) aborted = 1'b1; end
                stop_bit = tx;
                if (!aborted) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL mon_unexpected: frame 0x%02h on tx, no byte queued", b);
                    end else begin
                        e  = sb_q.pop_front();
                        ep = (FBITS == 11) ? ((^e) ^ odd_sel) : 1'b0;
                        if (b !== e || start_bit !== 1'b0 || stop_bit !== 1'b1 || par !== ep) begin
                            errors++;
                            $display("FAIL mon_frame: got data=0x%02h start=%b par=%b stop=%b, want data=0x%02h start=0 par=%b stop=1",
                                     b, start_bit, par, stop_bit, e, ep);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [63:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            errors++; $display("FAIL reset_held: tx=%b irq=%b, want tx=1 irq=0", tx, irq);
        end
        rst = 1'b0;
        @(negedge clk);
        rd(A_ST, d);
        checks++;
        if (d !== 64'h002) begin errors++; $display("FAIL reset_status: got 0x%0h want 0x2", d); end
        rd(A_CT, d);
        checks++;
        if (d !== 64'h0) begin errors++; $display("FAIL reset_ctrl: got 0x%0h want 0x0", d); end
        checks++;
        if (irq !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL reset_outputs: tx=%b irq=%b, want tx=1 irq=0", tx, irq);
        end
    endtask

    task automatic test_regmap();
        logic [63:0] d;
        ctrl_write(64'h7);
        rd(A_CT, d);
        checks++;
        if (d !== ((FBITS == 11) ? 64'h7 : 64'h3)) begin
            errors++; $display("FAIL ctrl_rw: got 0x%0h want 0x%0h", d, (FBITS == 11) ? 7 : 3);
        end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle: got %b want 1", irq); end
        @(negedge clk);
        put(A_RS, '1);
        put(12'h710, 64'h0);
        release_bus();
        rd(A_RS, d);
        checks++;
        if (d !== 64'h0) begin errors++; $display("FAIL reserved_read: got 0x%0h want 0x0", d); end
        rd(A_TX, d);
        checks++;
        if (d !== 64'h0) begin errors++; $display("FAIL txdata_read: got 0x%0h want 0x0", d); end
        rd(12'h710, d);
        checks++;
        if (d !== 64'h0) begin errors++; $display("FAIL outside_read: got 0x%0h want 0x0", d); end
        rd(A_CT, d);
        checks++;
        if (d[1:0] !== 2'b11) begin errors++; $display("FAIL outside_write: ctrl=0x%0h want low bits 3", d); end
        rd(A_ST, d);
        checks++;
        if (d !== 64'h002) begin errors++; $display("FAIL reserved_write: status=0x%0h want 0x2", d); end
    endtask

    task automatic test_single_byte();
        logic [63:0] d;
        logic        e;
        @(negedge clk);
        ctrl_write(64'h3);
        sb_q.push_back(8'hA5);
        put(A_TX, 64'hA5);
        release_bus();
        rd(A_ST, d);
        checks++;
        if (d !== 64'h100 || tx !== 1'b1) begin
            errors++; $display("FAIL single_pre: status=0x%0h tx=%b, want 0x100 tx=1", d, tx);
        end
        for (int c = 1; c <= FLEN; c++) begin
            @(negedge clk); #1;
            e = exp_bit(8'hA5, odd_sel, (c-1)/DIV);
            checks++;
            if (tx !== e || rdata[2] !== 1'b1 || irq !== 1'b0) begin
                errors++;
                $display("FAIL single_wave c=%0d: tx=%b busy=%b irq=%b, want tx=%b busy=1 irq=0", c, tx, rdata[2], irq, e);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (irq !== 1'b1 || rdata !== 64'h002 || tx !== 1'b1) begin
            errors++; $display("FAIL single_done: irq=%b status=0x%0h tx=%b, want irq=1 0x2 tx=1", irq, rdata, tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        logic [7:0]  b;
        logic        e;
        logic [3:0]  ec;
        ctrl_write(64'h2);
        sb_q.push_back(8'h55);
        sb_q.push_back(8'h0F);
        put(A_TX, 64'h55);
        put(A_TX, 64'h0F);
        release_bus();
        rd(A_ST, d);
        checks++;
        if (d[11:8] !== 4'd2 || d[2] !== 1'b0) begin
            errors++; $display("FAIL b2b_count2: count=%0d busy=%b, want 2 busy=0", d[11:8], d[2]);
        end
        ctrl_write(64'h3);
        for (int c = 1; c <= 2*FLEN; c++) begin
            @(negedge clk); #1;
            b = (c <= FLEN) ? 8'h55 : 8'h0F;
            e = exp_bit(b, odd_sel, ((c-1) % FLEN)/DIV);
            checks++;
            if (tx !== e || rdata[2] !== 1'b1) begin
                errors++; $display("FAIL b2b_wave c=%0d: tx=%b busy=%b, want tx=%b busy=1", c, tx, rdata[2], e);
            end
            if (c == 1 || c == FLEN || c == FLEN+1) begin
                ec = (c <= FLEN) ? 4'd1 : 4'd0;
                checks++;
                if (rdata[11:8] !== ec) begin
                    errors++; $display("FAIL b2b_count c=%0d: got %0d want %0d", c, rdata[11:8], ec);
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if (rdata !== 64'h002 || irq !== 1'b1) begin
            errors++; $display("FAIL b2b_done: status=0x%0h irq=%b, want 0x2 irq=1", rdata, irq);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] d;
        ctrl_write(64'h0);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) sb_q.push_back(8'h30 + 8'(i));
            put(A_TX, 64'h30 + 64'(i));
            release_bus();
        end
        rd(A_ST, d);
        checks++;
        if (d !== 64'h809) begin errors++; $display("FAIL ovf_status: got 0x%0h want 0x809", d); end
        put(A_ST, 64'h8);
        release_bus();
        rd(A_ST, d);
        checks++;
        if (d !== 64'h801) begin errors++; $display("FAIL ovf_clear: got 0x%0h want 0x801", d); end
    endtask

    task automatic test_full_pop();
        logic [63:0] d;
        int          n;
        @(negedge clk);
        put(A_CT, 64'h1);
        sb_q.push_back(8'h99);
        put(A_TX, 64'h99);
        release_bus();
        rd(A_ST, d);
        checks++;
        if (d !== 64'h805) begin errors++; $display("FAIL fullpop_status: got 0x%0h want 0x805", d); end
        n = 0;
        while (sb_q.size() != 0 && n < 9*FLEN + 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL fullpop_drain: %0d bytes still expected after %0d cycles, want 0", sb_q.size(), n);
        end
        repeat (DIV + 2) @(negedge clk);
        rd(A_ST, d);
        checks++;
        if (d !== 64'h002 || irq !== 1'b0) begin
            errors++; $display("FAIL fullpop_done: status=0x%0h irq=%b, want 0x2 irq=0", d, irq);
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [63:0] d;
        logic        e;
        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            ctrl_write((m == 0) ? 64'h3 : 64'h7);
            sb_q.push_back(8'h07);
            put(A_TX, 64'h07);
            release_bus();
            for (int c = 1; c <= 44; c++) begin
                @(negedge clk); #1;
                e = exp_bit(8'h07, odd_sel, (c-1)/DIV);
                checks++;
                if (tx !== e || rdata[2] !== 1'b1) begin
                    errors++; $display("FAIL parity_wave odd=%0d c=%0d: tx=%b busy=%b, want tx=%b busy=1", m, c, tx, rdata[2], e);
                end
            end
            @(negedge clk); #1;
            checks++;
            if (rdata[2] !== 1'b0) begin errors++; $display("FAIL parity_len odd=%0d: busy=%b at cycle 45, want 0", m, rdata[2]); end
        end
        ctrl_write(64'h3);
    endtask
`endif

    task automatic test_reset_midframe();
        logic [63:0] d;
        int          n;
        logic        stuck;
        @(negedge clk);
        ctrl_write(64'h3);
        put(A_TX, 64'hC3);
        release_bus();
        repeat ($urandom_range(1, 30)) @(negedge clk);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL midframe_setup: tx=%b, want 0 before reset", tx); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midframe_tx: got %b want 1", tx); end
        rd(A_ST, d);
        checks++;
        if (d !== 64'h002) begin errors++; $display("FAIL midframe_status: got 0x%0h want 0x2", d); end
        rd(A_CT, d);
        checks++;
        if (d !== 64'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL midframe_ctrl: ctrl=0x%0h irq=%b, want 0x0 irq=0", d, irq);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        stuck = 1'b1;
        for (int c = 0; c < 2*FLEN; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) stuck = 1'b0;
        end
        checks++;
        if (stuck !== 1'b1) begin errors++; $display("FAIL midframe_quiet: tx left idle after reset, want steady 1"); end
        rd(A_ST, d);
        checks++;
        if (d !== 64'h002) begin errors++; $display("FAIL midframe_after: got 0x%0h want 0x2", d); end
    endtask

    initial begin
        test_reset();
        test_regmap();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_full_pop();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: %0d bytes never transmitted, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
